// File: rtl/x_oddr_pkg.sv
// Shared types for the DDR output serialiser: FSM states and
// the pair-counter width helper.
package x_oddr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int width);
        return (width / 2 <= 2) ? 1 : $clog2(width / 2);
    endfunction

endpackage

// File: rtl/x_oddr_tx_if.sv
// Word handshake between the fabric source and the serialiser.
// The source drives D/DV; the serialiser answers with DRDY.
interface x_oddr_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic             DV;
    logic             DRDY;

    modport master (output D, output DV, input DRDY);
    modport slave  (input D, input DV, output DRDY);
endinterface

// File: rtl/x_oddr_hold.sv
// One-entry holding register in front of the shifter.
// A pop in the same edge as a push lets the entry refill while draining.
module x_oddr_hold
    import x_oddr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    x_oddr_tx_if.slave       bus,
    input  logic             pop,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic rdy_q;
    logic push;

    assign bus.DRDY = rdy_q & (~full | pop);
    assign push     = bus.DV & bus.DRDY;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            full  <= 1'b0;
            data  <= '0;
        end else begin
            rdy_q <= 1'b1;
            full  <= push | (full & ~pop);
            if (push) begin
                data <= bus.D;
            end
        end
    end

endmodule

// File: rtl/x_oddr_tx.sv
// DDR output serialiser: words in, two bits per clock out on Q1/Q2/OQ.
// Define X_ODDR_TX_TRISTATE_EN to add the TQ output enable.
module x_oddr_tx
    import x_oddr_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   MSB_FIRST = 1,
    parameter logic INIT_Q1   = 1'b0,
    parameter logic INIT_Q2   = 1'b0
) (
    input  logic       C,
    input  logic       R,
    x_oddr_tx_if.slave bus,
    output logic       Q1,
    output logic       Q2,
    output logic       OQ,
    output logic       BUSY,
`ifdef X_ODDR_TX_TRISTATE_EN
    output logic       TQ,
`endif
    output logic       DONE
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_n;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic             q1_n;
    logic             q2_n;
    logic             done_n;
    logic             pop;
    logic             load;
    logic             full;
    logic [WIDTH-1:0] hold_data;

    function automatic logic [1:0] head(input logic [WIDTH-1:0] w);
        if (MSB_FIRST != 0) begin
            return {w[WIDTH-1], w[WIDTH-2]};
        end
        return {w[0], w[1]};
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 2) : (w >> 2);
    endfunction

    x_oddr_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk  (C),
        .rst_n(R),
        .bus  (bus),
        .pop  (pop),
        .full (full),
        .data (hold_data)
    );

    // A held word enters the shifter from IDLE or on the last pair.
    assign load = full & ((state == IDLE) | (cnt == '0));

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        q1_n    = INIT_Q1;
        q2_n    = INIT_Q2;
        done_n  = 1'b0;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    pop          = 1'b1;
                    state_n      = SHIFT;
                    {q1_n, q2_n} = head(hold_data);
                    sh_n         = adv(hold_data);
                    cnt_n        = LAST;
                    done_n       = (LAST == '0);
                end
            end
            SHIFT: begin
                if (load) begin
                    pop          = 1'b1;
                    {q1_n, q2_n} = head(hold_data);
                    sh_n         = adv(hold_data);
                    cnt_n        = LAST;
                    done_n       = (LAST == '0);
                end else if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    {q1_n, q2_n} = head(sh);
                    sh_n         = adv(sh);
                    cnt_n        = cnt - 1'b1;
                    done_n       = (cnt == CW'(1));
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (!R) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            Q1    <= INIT_Q1;
            Q2    <= INIT_Q2;
            DONE  <= 1'b0;
        end else begin
            state <= state_n;
            sh    <= sh_n;
            cnt   <= cnt_n;
            Q1    <= q1_n;
            Q2    <= q2_n;
            DONE  <= done_n;
        end
    end

    assign BUSY = (state == SHIFT);

`ifdef X_ODDR_TX_TRISTATE_EN
    assign TQ = (state != SHIFT);
    assign OQ = TQ ? 1'bz : (C ? Q1 : Q2);
`else
    assign OQ = C ? Q1 : Q2;
`endif

endmodule
